evr_output_driver: RTL and testbench

- Event-receiver output channel.
- On a trigger strobe it generates a delayed pulse or plays a stored bit pattern.
- Output is one SERDES_WIDTH-bit word per clock, driving an output serializer.
- Configured by 32-bit CSR writes.
- Single clock domain; CSR writes arrive already synchronized to evrClk (CDC is the integrator's job).

---
 rtl/evr_output_driver_pkg.sv | 27 ++
 rtl/evr_output_driver_pattern_ram.sv | 30 +++
 rtl/evr_output_driver.sv | 213 +++++++++++++++++++++
 tb/tb_evr_output_driver.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/evr_output_driver_pkg.sv
// Shared definitions for the event-receiver output driver: CSR opcodes,
// channel modes, sequencer states and the CSR pattern-address field position.
package evr_output_driver_pkg;

    // CSR opcodes, carried in GPIO_OUT[31:30]
    localparam logic [1:0] SET_MODE    = 2'd0;
    localparam logic [1:0] SET_DELAY   = 2'd1;
    localparam logic [1:0] SET_WIDTH   = 2'd2;
    localparam logic [1:0] SET_PATTERN = 2'd3;

    // Bit position of the pattern RAM address inside a SET_PATTERN write
    localparam int CSR_PATTERN_ADDRESS_SHIFT = 10;

    typedef enum logic [1:0] {
        MODE_DISABLED       = 2'd0,
        MODE_PULSE          = 2'd1,
        MODE_PATTERN_SINGLE = 2'd2,
        MODE_PATTERN_LOOP   = 2'd3
    } mode_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DELAY  = 2'd1,
        ST_ACTIVE = 2'd2
    } state_t;

endpackage

// File: rtl/evr_output_driver_pattern_ram.sv
// Simple dual-port pattern store: synchronous write, registered read with a
// single cycle of latency. Contents are deliberately not reset.
module evr_output_driver_pattern_ram
    import evr_output_driver_pkg::*;
#(
    parameter int DATA_WIDTH = 4,
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [0:(1 << ADDR_WIDTH)-1];
    logic [DATA_WIDTH-1:0] rd_data_reg;

    // Write port and registered read port share the one clock
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data_reg <= mem[rd_addr];
    end

    assign rd_data = rd_data_reg;

endmodule

// File: rtl/evr_output_driver.sv
// Event-receiver output channel. A trigger starts a delayed pulse or plays a
// stored bit pattern, one SERDES_WIDTH-bit word per clock (bit 0 first).
// Optional macro EVR_OUTPUT_DRIVER_DEBUG_EN exposes dbgState / dbgAddress.
// The sequence index doubles as the RAM address, so PATTERN_ADDRESS_WIDTH
// must not exceed COARSE_WIDTH_WIDTH.
module evr_output_driver
    import evr_output_driver_pkg::*;
#(
    parameter int SERDES_WIDTH          = 4,
    parameter int COARSE_DELAY_WIDTH    = 22,
    parameter int COARSE_WIDTH_WIDTH    = 22,
    parameter int PATTERN_ADDRESS_WIDTH = 12
) (
    input  logic                    evrClk,
    input  logic                    evrReset,
    input  logic                    csrStrobe,
    input  logic [31:0]             GPIO_OUT,
    input  logic                    triggerStrobe,
    output logic [SERDES_WIDTH-1:0] serdesPattern
`ifdef EVR_OUTPUT_DRIVER_DEBUG_EN
    ,
    output logic [1:0]                       dbgState,
    output logic [PATTERN_ADDRESS_WIDTH-1:0] dbgAddress
`endif
);

    localparam int SW  = SERDES_WIDTH;
    localparam int CDW = COARSE_DELAY_WIDTH;
    localparam int CWW = COARSE_WIDTH_WIDTH;
    localparam int PAW = PATTERN_ADDRESS_WIDTH;

    // CSR decode
    logic [1:0] opcode;
    logic       mode_write;
    logic       pattern_write;
    logic       unused_gpio;

    assign opcode        = GPIO_OUT[31:30];
    assign mode_write    = csrStrobe && (opcode == SET_MODE);
    assign pattern_write = csrStrobe && (opcode == SET_PATTERN);
    assign unused_gpio   = ^GPIO_OUT;

    // CSR-visible configuration
    mode_t          mode_reg;
    logic [CDW-1:0] delay_reg;
    logic [CWW-1:0] width_reg;
    logic [SW-1:0]  first_reg;
    logic [SW-1:0]  last_reg;

    // Parameters captured at trigger time
    mode_t          seq_mode_reg;
    logic [CWW-1:0] seq_width_reg;
    logic [CWW-1:0] pulse_len_reg;
    logic [SW-1:0]  seq_first_reg;
    logic [SW-1:0]  seq_last_reg;

    // Sequencer
    state_t         state_reg;
    logic [CDW-1:0] delay_cnt_reg;
    logic [CWW-1:0] idx_reg;

    // Output pipeline
    logic          stage_valid_reg;
    logic          stage_pattern_reg;
    logic [SW-1:0] pulse_word_reg;
    logic [SW-1:0] pulse_word;
    logic [SW-1:0] serdes_reg;
    logic [SW-1:0] ram_rd_data;

    // An empty pattern run (width 0) goes straight back to idle
    logic start_empty;
    logic seq_empty;
    assign start_empty = (mode_reg != MODE_PULSE) && (width_reg == '0);
    assign seq_empty   = (seq_mode_reg != MODE_PULSE) && (seq_width_reg == '0);

    // Configuration registers written by CSR strobes
    always_ff @(posedge evrClk) begin
        if (evrReset) begin
            mode_reg  <= MODE_DISABLED;
            delay_reg <= '0;
            width_reg <= '0;
            first_reg <= '0;
            last_reg  <= '0;
        end else if (csrStrobe) begin
            case (opcode)
                SET_MODE:  mode_reg <= mode_t'(GPIO_OUT[1:0]);
                SET_DELAY: begin
                    first_reg <= GPIO_OUT[SW-1:0];
                    delay_reg <= GPIO_OUT[SW+CDW-1:SW];
                end
                SET_WIDTH: begin
                    last_reg  <= GPIO_OUT[SW-1:0];
                    width_reg <= GPIO_OUT[SW+CWW-1:SW];
                end
                default: ;
            endcase
        end
    end

    // Sequencer FSM: latch parameters on trigger, count delay, step through words
    always_ff @(posedge evrClk) begin
        if (evrReset) begin
            state_reg     <= ST_IDLE;
            delay_cnt_reg <= '0;
            idx_reg       <= '0;
            seq_mode_reg  <= MODE_DISABLED;
            seq_width_reg <= '0;
            pulse_len_reg <= '0;
            seq_first_reg <= '0;
            seq_last_reg  <= '0;
        end else if (mode_write) begin
            // Any mode write aborts; a coincident trigger is dropped
            state_reg     <= ST_IDLE;
            delay_cnt_reg <= '0;
            idx_reg       <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (triggerStrobe && (mode_reg != MODE_DISABLED)) begin
                        seq_mode_reg  <= mode_reg;
                        seq_width_reg <= width_reg;
                        pulse_len_reg <= (width_reg == '0) ? CWW'(1) : width_reg;
                        seq_first_reg <= first_reg;
                        seq_last_reg  <= last_reg;
                        idx_reg       <= '0;
                        if (delay_reg != '0) begin
                            state_reg     <= ST_DELAY;
                            delay_cnt_reg <= delay_reg - CDW'(1);
                        end else if (start_empty) begin
                            state_reg <= ST_IDLE;
                        end else begin
                            state_reg <= ST_ACTIVE;
                        end
                    end
                end
                ST_DELAY: begin
                    if (delay_cnt_reg == '0) begin
                        state_reg <= seq_empty ? ST_IDLE : ST_ACTIVE;
                    end else begin
                        delay_cnt_reg <= delay_cnt_reg - CDW'(1);
                    end
                end
                ST_ACTIVE: begin
                    if (seq_mode_reg == MODE_PULSE) begin
                        if (idx_reg == pulse_len_reg) begin
                            state_reg <= ST_IDLE;
                        end else begin
                            idx_reg <= idx_reg + CWW'(1);
                        end
                    end else if (idx_reg == seq_width_reg - CWW'(1)) begin
                        if (seq_mode_reg == MODE_PATTERN_LOOP) begin
                            idx_reg <= '0;
                        end else begin
                            state_reg <= ST_IDLE;
                        end
                    end else begin
                        idx_reg <= idx_reg + CWW'(1);
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    // Pulse word for the current index: first, all ones, then last
    always_comb begin
        pulse_word = '1;
        if (idx_reg == '0) begin
            pulse_word = seq_first_reg;
        end else if (idx_reg == pulse_len_reg) begin
            pulse_word = seq_last_reg;
        end
    end

    // Two-stage output pipeline: word select / RAM read, then output register
    always_ff @(posedge evrClk) begin
        if (evrReset || mode_write) begin
            stage_valid_reg   <= 1'b0;
            stage_pattern_reg <= 1'b0;
            pulse_word_reg    <= '0;
            serdes_reg        <= '0;
        end else begin
            stage_valid_reg   <= (state_reg == ST_ACTIVE);
            stage_pattern_reg <= (seq_mode_reg != MODE_PULSE);
            pulse_word_reg    <= pulse_word;
            if (stage_valid_reg) begin
                serdes_reg <= stage_pattern_reg ? ram_rd_data : pulse_word_reg;
            end else begin
                serdes_reg <= '0;
            end
        end
    end

    assign serdesPattern = serdes_reg;

    evr_output_driver_pattern_ram #(
        .DATA_WIDTH(SW),
        .ADDR_WIDTH(PAW)
    ) u_pattern_ram (
        .clk    (evrClk),
        .wr_en  (pattern_write),
        .wr_addr(GPIO_OUT[CSR_PATTERN_ADDRESS_SHIFT +: PAW]),
        .wr_data(GPIO_OUT[SW-1:0]),
        .rd_addr(idx_reg[PAW-1:0]),
        .rd_data(ram_rd_data)
    );

`ifdef EVR_OUTPUT_DRIVER_DEBUG_EN
    assign dbgState   = state_reg;
    assign dbgAddress = idx_reg[PAW-1:0];
`endif

endmodule

// File: tb/tb_evr_output_driver.sv
// Self-checking bench for evr_output_driver: a cycle-by-cycle vector table for
// the pulse / single-pattern corner cases, then scripted multi-cycle runs
// (loop, single with repeated triggers, mode changes, reset) checked against
// an output schedule built by the bench.
module tb_evr_output_driver;

    logic        clk;
    logic        evrReset;
    logic        csrStrobe;
    logic [31:0] GPIO_OUT;
    logic        triggerStrobe;
    logic [3:0]  serdesPattern;

    int n_checks = 0;
    int n_fail   = 0;

    evr_output_driver dut (
        .evrClk       (clk),
        .evrReset     (evrReset),
        .csrStrobe    (csrStrobe),
        .GPIO_OUT     (GPIO_OUT),
        .triggerStrobe(triggerStrobe),
        .serdesPattern(serdesPattern)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        csr;
        logic [31:0] data;
        logic        trig;
        logic        rst;
        logic [3:0]  exp;
    } vec_t;

    vec_t vecs[$];

    localparam int SIZE = 700;
    int         ev_mode [SIZE];
    bit         ev_trig [SIZE];
    bit         ev_rst  [SIZE];
    logic [3:0] sched   [SIZE];
    logic [3:0] pat     [5];
    int md, mw;
    logic [3:0] mf, ml;

    function automatic logic [31:0] enc_mode(input logic [1:0] m);
        return {2'b00, 28'd0, m};
    endfunction
    function automatic logic [31:0] enc_delay(input logic [21:0] d, input logic [3:0] f);
        return {2'b01, 4'd0, d, f};
    endfunction
    function automatic logic [31:0] enc_width(input logic [21:0] w, input logic [3:0] l);
        return {2'b10, 4'd0, w, l};
    endfunction
    function automatic logic [31:0] enc_pat(input logic [11:0] a, input logic [3:0] v);
        return {2'b11, 8'd0, a, 6'd0, v};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: serdesPattern=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic add_vec(input logic csr, input logic [31:0] d, input logic trig,
                           input logic rst, input logic [3:0] e);
        vec_t v;
        v.csr = csr; v.data = d; v.trig = trig; v.rst = rst; v.exp = e;
        vecs.push_back(v);
    endtask

    task automatic csr_write(input logic [31:0] d);
        csrStrobe = 1'b1; GPIO_OUT = d; triggerStrobe = 1'b0; evrReset = 1'b0;
        tick();
        csrStrobe = 1'b0; GPIO_OUT = '0;
    endtask

    task automatic set_delay(input int d, input logic [3:0] f);
        md = d; mf = f;
        csr_write(enc_delay(22'(d), f));
    endtask

    task automatic set_width(input int w, input logic [3:0] l);
        mw = w; ml = l;
        csr_write(enc_width(22'(w), l));
    endtask

    task automatic clear_events();
        for (int k = 0; k < SIZE; k++) begin
            ev_mode[k] = -1; ev_trig[k] = 1'b0; ev_rst[k] = 1'b0; sched[k] = 4'h0;
        end
    endtask

    task automatic put(input int k, input logic [3:0] v);
        if (k < SIZE) sched[k] = v;
    endtask

    // Applies the event script for n cycles; expected output comes from a
    // schedule of future words filled in whenever a trigger is accepted.
    task automatic run_script(input string tag, input int n);
        int m_mode = 0;
        int busy   = -1;
        int base, wp;
        for (int c = 0; c < n; c++) begin
            csrStrobe     = (ev_mode[c] >= 0);
            GPIO_OUT      = (ev_mode[c] >= 0) ? enc_mode(2'(ev_mode[c])) : 32'd0;
            triggerStrobe = ev_trig[c];
            evrReset      = ev_rst[c];
            if (ev_rst[c] || ev_mode[c] >= 0) begin
                for (int k = c; k < SIZE; k++) sched[k] = 4'h0;
                busy = -1;
                if (ev_rst[c]) begin
                    m_mode = 0; md = 0; mw = 0; mf = 4'h0; ml = 4'h0;
                end else begin
                    m_mode = ev_mode[c];
                end
            end else if (ev_trig[c] && m_mode != 0 && c > busy) begin
                base = c + 2 + md;
                if (m_mode == 1) begin
                    wp = (mw == 0) ? 1 : mw;
                    for (int i = 0; i <= wp; i++)
                        put(base + i, (i == 0) ? mf : (i == wp) ? ml : 4'hF);
                    busy = base + wp;
                end else if (mw == 0) begin
                    busy = c + md + 1;
                end else if (m_mode == 2) begin
                    for (int i = 0; i < mw; i++) put(base + i, pat[i]);
                    busy = base + mw - 1;
                end else begin
                    for (int k = base; k < SIZE; k++) sched[k] = pat[(k - base) % mw];
                    busy = 1 << 30;
                end
            end
            tick();
            check($sformatf("%s c=%0d", tag, c), serdesPattern, sched[c]);
        end
        csrStrobe = 1'b0; GPIO_OUT = '0; triggerStrobe = 1'b0; evrReset = 1'b0;
    endtask

    initial begin
        evrReset = 1'b1; csrStrobe = 1'b0; GPIO_OUT = '0; triggerStrobe = 1'b0;
        pat[0] = 4'hF; pat[1] = 4'h1; pat[2] = 4'h0; pat[3] = 4'h0; pat[4] = 4'h7;
        md = 0; mw = 0; mf = 4'h0; ml = 4'h0;

        // Reset state
        add_vec(0, 0, 0, 1, 4'h0);
        add_vec(0, 0, 0, 1, 4'h0);
        add_vec(0, 0, 1, 0, 4'h0);
        // Pulse, delay 0, width 10, first/last 0xF: 11 words of 0xF from t+2
        add_vec(1, enc_delay(0, 4'hF), 0, 0, 4'h0);
        add_vec(1, enc_width(10, 4'hF), 0, 0, 4'h0);
        add_vec(1, enc_mode(2'd1), 0, 0, 4'h0);
        add_vec(0, 0, 1, 0, 4'h0);
        add_vec(0, 0, 0, 0, 4'h0);
        for (int i = 0; i < 11; i++) add_vec(0, 0, 0, 0, 4'hF);
        for (int i = 0; i < 3; i++) add_vec(0, 0, 0, 0, 4'h0);
        // Pulse edges, delay 3: 0x3, 0xF, 0xC from t+5; width rewrite and
        // extra triggers mid-sequence must not disturb it
        add_vec(1, enc_delay(3, 4'h3), 0, 0, 4'h0);
        add_vec(1, enc_width(2, 4'hC), 0, 0, 4'h0);
        add_vec(0, 0, 1, 0, 4'h0);
        add_vec(1, enc_width(5, 4'h0), 0, 0, 4'h0);
        add_vec(0, 0, 1, 0, 4'h0);
        add_vec(0, 0, 0, 0, 4'h0);
        add_vec(0, 0, 0, 0, 4'h0);
        add_vec(0, 0, 1, 0, 4'h3);
        add_vec(0, 0, 0, 0, 4'hF);
        add_vec(0, 0, 0, 0, 4'hC);
        for (int i = 0; i < 4; i++) add_vec(0, 0, 0, 0, 4'h0);
        // Pulse width 0 behaves as width 1: first then last
        add_vec(1, enc_delay(0, 4'h5), 0, 0, 4'h0);
        add_vec(1, enc_width(0, 4'hA), 0, 0, 4'h0);
        add_vec(0, 0, 1, 0, 4'h0);
        add_vec(0, 0, 0, 0, 4'h0);
        add_vec(0, 0, 0, 0, 4'h5);
        add_vec(0, 0, 0, 0, 4'hA);
        add_vec(0, 0, 0, 0, 4'h0);
        add_vec(0, 0, 0, 0, 4'h0);
        // Mode write coincident with trigger: trigger dropped
        add_vec(1, enc_mode(2'd1), 1, 0, 4'h0);
        for (int i = 0; i < 4; i++) add_vec(0, 0, 0, 0, 4'h0);
        // Disabled: triggers ignored
        add_vec(1, enc_mode(2'd0), 0, 0, 4'h0);
        add_vec(0, 0, 1, 0, 4'h0);
        for (int i = 0; i < 4; i++) add_vec(0, 0, 0, 0, 4'h0);
        // Pattern RAM contents
        for (int i = 0; i < 5; i++) add_vec(1, enc_pat(12'(i), pat[i]), 0, 0, 4'h0);
        // Single pattern, width 0: nothing plays
        add_vec(1, enc_delay(2, 4'h0), 0, 0, 4'h0);
        add_vec(1, enc_width(0, 4'h0), 0, 0, 4'h0);
        add_vec(1, enc_mode(2'd2), 0, 0, 4'h0);
        add_vec(0, 0, 1, 0, 4'h0);
        for (int i = 0; i < 6; i++) add_vec(0, 0, 0, 0, 4'h0);
        // Single pattern, width 4, delay 0: F,1,0,0 then stop before RAM[4]
        add_vec(1, enc_delay(0, 4'h0), 0, 0, 4'h0);
        add_vec(1, enc_width(4, 4'h0), 0, 0, 4'h0);
        add_vec(0, 0, 1, 0, 4'h0);
        add_vec(0, 0, 0, 0, 4'h0);
        add_vec(0, 0, 0, 0, 4'hF);
        add_vec(0, 0, 0, 0, 4'h1);
        add_vec(0, 0, 0, 0, 4'h0);
        add_vec(0, 0, 0, 0, 4'h0);
        for (int i = 0; i < 4; i++) add_vec(0, 0, 0, 0, 4'h0);

        foreach (vecs[i]) begin
            csrStrobe     = vecs[i].csr;
            GPIO_OUT      = vecs[i].data;
            triggerStrobe = vecs[i].trig;
            evrReset      = vecs[i].rst;
            tick();
            check($sformatf("vec[%0d]", i), serdesPattern, vecs[i].exp);
        end
        csrStrobe = 1'b0; GPIO_OUT = '0; triggerStrobe = 1'b0; evrReset = 1'b0;

        // Loop: ignored trigger while looping, abort by rewrite, restart, disable
        set_delay(0, 4'h0);
        set_width(4, 4'h0);
        clear_events();
        ev_mode[0] = 3; ev_trig[5] = 1'b1; ev_trig[20] = 1'b1;
        ev_mode[60] = 3; ev_trig[70] = 1'b1; ev_mode[90] = 0; ev_trig[95] = 1'b1;
        run_script("loop", 110);

        // Single: one burst per trigger, mid-burst trigger ignored
        set_delay(2, 4'h0);
        clear_events();
        ev_mode[0] = 2; ev_trig[5] = 1'b1; ev_trig[7] = 1'b1; ev_trig[133] = 1'b1;
        run_script("single", 150);

        // Mode changes every 100 cycles with periodic triggers
        set_delay(1, 4'h3);
        set_width(4, 4'hC);
        clear_events();
        ev_mode[0] = 3; ev_mode[100] = 2; ev_mode[200] = 2;
        ev_mode[300] = 1; ev_mode[400] = 3; ev_mode[500] = 1;
        for (int c = 15; c < 600; c += 30) ev_trig[c] = 1'b1;
        ev_trig[300] = 1'b1;
        run_script("modes", 600);

        // Reset mid-loop, then triggers produce nothing
        set_delay(0, 4'h0);
        set_width(4, 4'h0);
        clear_events();
        ev_mode[0] = 3; ev_trig[5] = 1'b1; ev_rst[40] = 1'b1;
        ev_trig[50] = 1'b1; ev_trig[60] = 1'b1;
        run_script("reset", 80);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
